cte_stream: RTL

Parametrised, handshake-driven colour transform engine for the ICC2009 CTE pipeline. It converts a YUV 4:2:2 sample stream (U,Y0,V,Y1) into RGB pixels, or RGB pixels back into YUV 4:2:2 samples, selected by `mode` at pair boundaries. Input uses valid/ready and output uses valid/ready, with an internal output FIFO in place of the fixed busy/out_valid cadence. Upstream is the pixel source; downstream is the frame writer or the comparator.

---
 rtl/cte_stream_if.sv | 22 ++
 rtl/cte_stream.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cte_stream_if.sv
// Stream bundle for the colour transform engine: input words in, converted samples/pixels out.
// The slave view belongs to the engine; the master view to the source/sink environment.
interface cte_stream_if #(
   parameter int unsigned BW = 8
) ();
   logic            in_valid;
   logic            in_ready;
   logic [3*BW-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [3*BW-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/cte_stream.sv
// YUV 4:2:2 <-> RGB colour transform engine with valid/ready input and a FIFO-buffered output.
// Direction is latched at pair boundaries; flush aborts the pair and empties the FIFO.
module cte_stream #(
   parameter int unsigned BW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode_i,
   input  logic                   flush_i,
   cte_stream_if.slave            strm_io,
   output logic [$clog2(DEPTH):0] fifo_count_o,
   output logic [1:0]             phase_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = 3 * BW;
   localparam int unsigned W  = BW + 7;
   localparam int unsigned W2 = BW + 10;

   localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

   localparam logic signed [W-1:0]  C4   = W'(4);
   localparam logic signed [W-1:0]  C6   = W'(6);
   localparam logic signed [W-1:0]  C13  = W'(13);
   localparam logic signed [W2-1:0] C21  = W2'(21);
   localparam logic signed [W2-1:0] C29  = W2'(29);
   localparam logic signed [W2-1:0] C43  = W2'(43);
   localparam logic signed [W2-1:0] C77  = W2'(77);
   localparam logic signed [W2-1:0] C85  = W2'(85);
   localparam logic signed [W2-1:0] C107 = W2'(107);
   localparam logic signed [W2-1:0] C128 = W2'(128);
   localparam logic signed [W2-1:0] C150 = W2'(150);

   typedef enum logic [1:0] {Ph0, Ph1, Ph2, Ph3} phase_e;

   function automatic logic [BW-1:0] clamp_u(input logic signed [W2-1:0] x);
      if (x[W2-1]) begin
         return '0;
      end else if (|x[W2-2:BW]) begin
         return '1;
      end
      return x[BW-1:0];
   endfunction

   function automatic logic [BW-1:0] clamp_s(input logic signed [W2-1:0] x);
      if (!x[W2-1] && (|x[W2-2:BW-1])) begin
         return {1'b0, {(BW-1){1'b1}}};
      end else if (x[W2-1] && !(&x[W2-2:BW-1])) begin
         return {1'b1, {(BW-1){1'b0}}};
      end
      return x[BW-1:0];
   endfunction

   function automatic logic [DW-1:0] yuv2rgb(input logic [BW-1:0] y, input logic [BW-1:0] u,
                                             input logic [BW-1:0] v);
      logic signed [W-1:0] ys, us, vs, r, g, b;
      ys = signed'(W'(y));
      us = W'(signed'(u));
      vs = W'(signed'(v));
      r  = (ys <<< 3) + C13 * vs + C4;
      g  = (ys <<< 3) - (us <<< 1) - C6 * vs + C4;
      b  = (ys <<< 3) + (us <<< 4) + C4;
      return {clamp_u(W2'(r >>> 3)), clamp_u(W2'(g >>> 3)), clamp_u(W2'(b >>> 3))};
   endfunction

   // Returns {Y, U, V} for one RGB pixel.
   function automatic logic [DW-1:0] rgb2yuv(input logic [DW-1:0] rgb);
      logic signed [W2-1:0] r, g, b, y, u, v;
      r = signed'(W2'(rgb[3*BW-1:2*BW]));
      g = signed'(W2'(rgb[2*BW-1:BW]));
      b = signed'(W2'(rgb[BW-1:0]));
      y = C77 * r + C150 * g + C29 * b + C128;
      u = C128 * b - C43 * r - C85 * g + C128;
      v = C128 * r - C107 * g - C21 * b + C128;
      return {clamp_u(y >>> 8), clamp_s(u >>> 8), clamp_s(v >>> 8)};
   endfunction

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   phase_e        phase_q;
   logic          pending_q, mode_q;
   logic [BW-1:0] u_q, y_q, v_q;

   logic          full, pop, space, boundary, mode_eff, accept, pend_wr, push;
   logic [BW-1:0] smp, yc, uc, vc;
   logic [DW-1:0] pix, push_data;

   assign full              = (count_q == FullCnt);
   assign strm_io.out_valid = (count_q != '0);
   assign strm_io.out_data  = mem_q[rd_ptr_q];
   assign pop               = strm_io.out_valid & strm_io.out_ready & ~flush_i;
   assign space             = ~full | pop;
   assign boundary          = (phase_q == Ph0) & ~pending_q;
   // At a boundary the incoming mode takes effect for the word accepted in that same cycle.
   assign mode_eff          = boundary ? mode_i : mode_q;
   assign smp               = strm_io.in_data[BW-1:0];
   assign {yc, uc, vc}      = rgb2yuv(strm_io.in_data);
   assign pix               = yuv2rgb((phase_q == Ph3) ? smp : y_q, u_q,
                                      (phase_q == Ph3) ? v_q : smp);

   always_comb begin
      strm_io.in_ready = 1'b0;
      if (!flush_i) begin
         if (mode_eff) begin
            strm_io.in_ready = ~pending_q & space;
         end else begin
            strm_io.in_ready = phase_q[1] ? space : 1'b1;
         end
      end
   end

   assign accept  = strm_io.in_valid & strm_io.in_ready;
   assign pend_wr = pending_q & space & ~flush_i;
   assign push    = pend_wr | (accept & (mode_eff | phase_q[1]));

   always_comb begin
      push_data = '0;
      if (pend_wr) begin
         push_data[BW-1:0] = y_q;
      end else if (mode_eff) begin
         push_data[BW-1:0] = (phase_q == Ph0) ? uc : v_q;
      end else begin
         push_data = pix;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q   <= Ph0;
         pending_q <= 1'b0;
         mode_q    <= 1'b0;
         u_q       <= '0;
         y_q       <= '0;
         v_q       <= '0;
      end else if (flush_i) begin
         phase_q   <= Ph0;
         pending_q <= 1'b0;
      end else begin
         mode_q <= mode_eff;
         if (accept) begin
            phase_q <= phase_e'(phase_q + 2'd1);
            if (mode_eff) begin
               // RGB: chroma comes from pixel0 only; luma of either pixel is emitted next cycle.
               pending_q <= 1'b1;
               y_q       <= yc;
               if (phase_q == Ph0) begin
                  v_q <= vc;
               end
            end else begin
               case (phase_q)
                  Ph0:     u_q <= smp;
                  Ph1:     y_q <= smp;
                  Ph2:     v_q <= smp;
                  default: ;
               endcase
            end
         end else if (pend_wr) begin
            pending_q <= 1'b0;
            phase_q   <= phase_e'(phase_q + 2'd1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: ;
         endcase
      end
   end

   assign fifo_count_o = count_q;
   assign phase_o      = phase_q;

endmodule
